// File: rtl/uart_rx_framed_pkg.sv
// uart_rx_framed_pkg: shared FSM state encoding, default bit period and line idle level for the UART receiver.
package uart_rx_framed_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_BREAK
    } state_e;
    localparam int unsigned CPB_DEFAULT = 434;
    localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for the asynchronous serial line; resets to the idle level.
module uart_rx_sync
    import uart_rx_framed_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: 8N1 UART receiver with framing/parity error pulses and break handling.
// Define UART_RX_PARITY_EN to build the parity bit check (otherwise o_PARITY_ERR is constant 0).
module uart_rx_framed
    import uart_rx_framed_pkg::*;
#(
    parameter int unsigned c_CYCLES_PER_BIT = CPB_DEFAULT,
    parameter int unsigned c_DATA_BITS      = 8,
    parameter bit          c_PARITY_ODD     = 1'b0
) (
    input  logic                   i_CLK,
    input  logic                   i_RESET,
    input  logic                   i_SERIAL_DATA,
    output logic [c_DATA_BITS-1:0] o_DATA_RX,
    output logic                   o_RX_DATA_VALID,
    output logic                   o_RX_ACTIVE,
    output logic                   o_FRAME_ERR,
    output logic                   o_PARITY_ERR
);
    localparam int unsigned CW = $clog2(c_CYCLES_PER_BIT);
    localparam int unsigned IW = (c_DATA_BITS > 1) ? $clog2(c_DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF = CW'((c_CYCLES_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(c_CYCLES_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(c_DATA_BITS - 1);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [c_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
    logic rx, last, pbad;

    uart_rx_sync u_sync (
        .clk_i(i_CLK),
        .rst_i(i_RESET),
        .d_i  (i_SERIAL_DATA),
        .q_o  (rx)
    );

    assign last = cnt_q == LAST;

`ifdef UART_RX_PARITY_EN
    localparam state_e S_AFTER_DATA = S_PARITY;
    logic pbad_q, pbad_d;
    assign pbad_d = (state_q == S_PARITY && last) ? (rx != (^shift_q ^ c_PARITY_ODD)) : pbad_q;
    always_ff @(posedge i_CLK) begin
        if (i_RESET) pbad_q <= 1'b0;
        else pbad_q <= pbad_d;
    end
    assign pbad = pbad_q;
`else
    localparam state_e S_AFTER_DATA = S_STOP;
    // Parity sense has no meaning without a parity bit, so the mismatch flag is constant.
    assign pbad = c_PARITY_ODD & 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = rx ? S_IDLE : S_START;
            end
            S_START: begin
                idx_d = '0;
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: if (last) begin
                shift_d[idx_q] = rx;
                idx_d          = idx_q + 1'b1;
                state_d        = (idx_q == IDX_LAST) ? S_AFTER_DATA : S_DATA;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: state_d = last ? S_STOP : S_PARITY;
`endif
            S_STOP: if (last) begin
                ferr_d  = !rx;
                perr_d  = rx && pbad;
                valid_d = rx && !pbad;
                data_d  = (rx && !pbad) ? shift_q : data_q;
                state_d = rx ? S_CLEANUP : S_BREAK;
            end
            S_CLEANUP: state_d = S_IDLE;
            S_BREAK: state_d = rx ? S_IDLE : S_BREAK;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    assign o_DATA_RX       = data_q;
    assign o_RX_DATA_VALID = valid_q;
    assign o_RX_ACTIVE     = state_q != S_IDLE;
    assign o_FRAME_ERR     = ferr_q;
    assign o_PARITY_ERR    = perr_q;
endmodule
